// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size encodings, FSM states and byte-lane helpers for the LSU RAM master.
package lsu_pkg;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_e;

    function automatic logic [63:0] size_mask(input logic [1:0] size);
        return size == SZ_D ? '1 : (64'd1 << (7'd8 << size)) - 64'd1;
    endfunction

    function automatic logic [7:0] strb_gen(input logic [1:0] size, input logic [2:0] off);
        logic [7:0] m;
        m = 8'((9'd1 << (4'd1 << size)) - 9'd1);
        return m << off;
    endfunction
endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: extracts the addressed bytes of a RAM word and sign/zero extends them to 64 bits.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [2:0]  off,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [63:0] result
);
    logic [63:0] sh;

    always_comb begin
        sh = rdata >> {off, 3'b000};
        result = size == SZ_B ? {{56{~is_unsigned & sh[7]}}, sh[7:0]} :
                 size == SZ_H ? {{48{~is_unsigned & sh[15]}}, sh[15:0]} :
                 size == SZ_W ? {{32{~is_unsigned & sh[31]}}, sh[31:0]} : sh;
    end
endmodule

// File: rtl/lsu_ram_master.sv
// lsu_ram_master: single-outstanding LSU initiator for the split read/write simulation RAM port.
module lsu_ram_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [63:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [63:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [63:0]       ram_rdata,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [63:0]       ram_wdata,
    output logic [7:0]        ram_wstrb,
    output logic              ram_wen
);
    localparam int CW = RD_LAT > 1 ? $clog2(RD_LAT) : 1;

    state_e            state;
    logic              wen_q;
    logic              uns_q;
    logic [1:0]        size_q;
    logic [2:0]        off_q;
    logic [CW-1:0]     cnt;
    logic [63:0]       ld_data;
    logic              mis;
    logic [ADDR_W-1:0] aligned;

    assign mis     = |(req_addr[2:0] & 3'((4'd1 << req_size) - 4'd1));
    assign aligned = {req_addr[ADDR_W-1:3], 3'b000};

    lsu_load_align u_align (
        .rdata       (ram_rdata),
        .off         (off_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .result      (ld_data)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            ram_wen    <= 1'b0;
            ram_wstrb  <= '0;
            ram_raddr  <= '0;
            ram_waddr  <= '0;
            ram_wdata  <= '0;
            cnt        <= '0;
            wen_q      <= 1'b0;
            uns_q      <= 1'b0;
            size_q     <= '0;
            off_q      <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    req_ready <= 1'b0;
                    wen_q     <= req_wen;
                    uns_q     <= req_unsigned;
                    size_q    <= req_size;
                    off_q     <= req_addr[2:0];
                    // Misaligned requests skip the RAM entirely
                    if (mis) begin
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        ram_raddr <= aligned;
                        ram_waddr <= aligned;
                        ram_wen   <= req_wen;
                        ram_wstrb <= req_wen ? strb_gen(req_size, req_addr[2:0]) : 8'h00;
                        ram_wdata <= req_wen ? (req_wdata & size_mask(req_size)) << {req_addr[2:0], 3'b000} : ram_wdata;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    ram_wen   <= 1'b0;
                    ram_wstrb <= '0;
                    if (wen_q) begin
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        cnt   <= CW'(RD_LAT - 1);
                        state <= WAIT;
                    end
                end
                WAIT: if (cnt == '0) begin
                    resp_rdata <= ld_data;
                    resp_err   <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end else begin
                    cnt <= cnt - CW'(1);
                end
                RESP: if (resp_ready) begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_ram_master.sv
// tb_lsu_ram_master: scoreboard bench driving RD_LAT=1 and RD_LAT=3 instances with shared requests.
module tb_lsu_ram_master;
    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          due;
        logic [63:0] raddr;
        int          wens;
    } exp_t;
    typedef struct {
        logic [63:0] addr;
        logic [7:0]  strb;
        logic [63:0] data;
    } wr_t;

    logic clock = 0;
    logic reset = 1;
    always #5 clock = ~clock;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic        req_valid = 0, req_wen = 0, req_unsigned = 0, resp_ready = 0;
    logic [63:0] req_addr = 0, req_wdata = 0;
    logic [1:0]  req_size = 0;
    logic        req_ready[2], resp_valid[2], resp_err[2], ram_wen[2];
    logic [63:0] resp_rdata[2], ram_raddr[2], ram_rdata[2], ram_waddr[2], ram_wdata[2];
    logic [7:0]  ram_wstrb[2];

    lsu_ram_master #(.ADDR_W(64), .RD_LAT(1)) dut1 (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready[0]),
        .req_wen(req_wen), .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata), .resp_valid(resp_valid[0]), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]), .ram_raddr(ram_raddr[0]),
        .ram_rdata(ram_rdata[0]), .ram_waddr(ram_waddr[0]), .ram_wdata(ram_wdata[0]),
        .ram_wstrb(ram_wstrb[0]), .ram_wen(ram_wen[0])
    );
    lsu_ram_master #(.ADDR_W(64), .RD_LAT(3)) dut3 (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready[1]),
        .req_wen(req_wen), .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata), .resp_valid(resp_valid[1]), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]), .ram_raddr(ram_raddr[1]),
        .ram_rdata(ram_rdata[1]), .ram_waddr(ram_waddr[1]), .ram_wdata(ram_wdata[1]),
        .ram_wstrb(ram_wstrb[1]), .ram_wen(ram_wen[1])
    );

    int pass_cnt = 0, tot_cnt = 0;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic int lat(input int i);
        return i == 0 ? 1 : 3;
    endfunction

    // Memories: one per RAM instance plus the reference view, all lazily initialised
    logic [63:0] mem0[logic [63:0]], mem1[logic [63:0]], refm[logic [63:0]];
    function automatic logic [63:0] init_w(input logic [63:0] a);
        return {a[31:0] ^ 32'h9e3779b9, ~a[31:0] ^ 32'h01234567};
    endfunction
    function automatic logic [63:0] rd(input int i, input logic [63:0] a);
        if (i == 0) return mem0.exists(a) ? mem0[a] : init_w(a);
        if (i == 1) return mem1.exists(a) ? mem1[a] : init_w(a);
        return refm.exists(a) ? refm[a] : init_w(a);
    endfunction
    task automatic wr(input int i, input logic [63:0] a, input logic [7:0] strb, input logic [63:0] d);
        logic [63:0] w;
        w = rd(i, a);
        for (int b = 0; b < 8; b++) if (strb[b]) w[8*b +: 8] = d[8*b +: 8];
        if (i == 0) mem0[a] = w;
        else if (i == 1) mem1[a] = w;
        else refm[a] = w;
    endtask

    function automatic logic [63:0] exp_load(input logic [63:0] w, input int off, input int sz, input bit uns);
        int n;
        logic [63:0] v, m;
        n = 8 << sz;
        v = w >> (8 * off);
        if (n < 64) begin
            m = (64'd1 << n) - 64'd1;
            v = v & m;
            if (!uns && v[n-1]) v = v | ~m;
        end
        return v;
    endfunction

    exp_t sq[2][$];
    wr_t  wq[2][$];
    int   wens_model = 0;
    logic [63:0] last_raddr = 0;
    int   wen_cnt[2] = '{0, 0};
    int   age[2] = '{100, 100};

    // RAM model: data is only valid in the cycle RD_LAT after the address first appears
    always @(posedge clock)
        for (int i = 0; i < 2; i++) age[i] <= (req_valid && req_ready[i]) ? 0 : age[i] + 1;

    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (ram_wen[i]) begin
                wr_t w;
                wen_cnt[i]++;
                if (wq[i].size() == 0) chk("unexpected_write", 1, 0);
                else begin
                    w = wq[i].pop_front();
                    chk("waddr", ram_waddr[i], w.addr);
                    chk("wstrb", 64'(ram_wstrb[i]), 64'(w.strb));
                    chk("wdata", ram_wdata[i], w.data);
                end
                wr(i, ram_waddr[i], ram_wstrb[i], ram_wdata[i]);
            end
            ram_rdata[i] = (age[i] == lat(i)) ? rd(i, ram_raddr[i]) : 64'h5a5a_5a5a_c3c3_c3c3;
        end
    end

    logic pv[2] = '{0, 0}, hs[2] = '{0, 0}, herr[2];
    logic [63:0] held[2];
    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                pv[i] = 0;
                hs[i] = 0;
            end else begin
                if (pv[i] && hs[i]) begin
                    chk("ready_after_hs", 64'(req_ready[i]), 1);
                    chk("valid_after_hs", 64'(resp_valid[i]), 0);
                end else if (resp_valid[i] && !pv[i]) begin
                    exp_t e;
                    if (sq[i].size() == 0) chk("unexpected_resp", 1, 0);
                    else begin
                        e = sq[i].pop_front();
                        chk("resp_cycle", 64'(cyc), 64'(e.due));
                        chk("resp_rdata", resp_rdata[i], e.rdata);
                        chk("resp_err", 64'(resp_err[i]), 64'(e.err));
                        chk("ram_raddr", ram_raddr[i], e.raddr);
                        chk("wen_pulses", 64'(wen_cnt[i]), 64'(e.wens));
                    end
                    held[i] = resp_rdata[i];
                    herr[i] = resp_err[i];
                end else if (pv[i]) begin
                    chk("valid_held", 64'(resp_valid[i]), 1);
                    chk("rdata_held", resp_rdata[i], held[i]);
                    chk("err_held", 64'(resp_err[i]), 64'(herr[i]));
                end
                if (resp_valid[i]) chk("ready_low_in_resp", 64'(req_ready[i]), 0);
                pv[i] = resp_valid[i];
                hs[i] = resp_valid[i] && resp_ready;
            end
        end
    end

    bit rr_rand = 0, rr_force = 1;
    always @(posedge clock) begin
        #1;
        resp_ready = rr_rand ? 1'($urandom_range(0, 1)) : rr_force;
    end

    task automatic issue(input bit wen, input logic [63:0] addr, input int sz, input bit uns,
                         input logic [63:0] wd, input bit push);
        int k, off, t;
        bit mis;
        logic [63:0] al, d;
        logic [7:0] s;
        exp_t e;
        k = 0;
        @(negedge clock);
        while (!(req_ready[0] && req_ready[1]) && k < 300) begin
            @(negedge clock);
            k++;
        end
        if (k >= 300) begin
            chk("issue_timeout", 1, 0);
            return;
        end
        req_wen = wen; req_addr = addr; req_size = 2'(sz); req_unsigned = uns; req_wdata = wd;
        req_valid = 1;
        t = cyc;
        off = int'(addr % 8);
        al = addr - 64'(off);
        mis = (addr % (64'd1 << sz)) != 0;
        if (push) begin
            if (!mis) last_raddr = al;
            if (wen && !mis) begin
                s = 0;
                d = 0;
                for (int b = 0; b < (1 << sz); b++) begin
                    s[off+b] = 1;
                    d[8*(off+b) +: 8] = wd[8*b +: 8];
                end
                wens_model++;
                for (int i = 0; i < 2; i++) wq[i].push_back('{addr: al, strb: s, data: d});
            end
            for (int i = 0; i < 2; i++) begin
                e.err   = mis;
                e.due   = t + (mis ? 1 : wen ? 2 : 2 + lat(i));
                e.rdata = (mis || wen) ? 64'd0 : exp_load(rd(2, al), off, sz, uns);
                e.raddr = last_raddr;
                e.wens  = wens_model;
                sq[i].push_back(e);
            end
            if (wen && !mis) wr(2, al, s, d);
        end
        @(posedge clock);
        #1 req_valid = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        repeat (3) @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            chk("rst_req_ready", 64'(req_ready[i]), 1);
            chk("rst_resp_valid", 64'(resp_valid[i]), 0);
            chk("rst_resp_err", 64'(resp_err[i]), 0);
            chk("rst_resp_rdata", resp_rdata[i], 0);
            chk("rst_ram_wen", 64'(ram_wen[i]), 0);
            chk("rst_ram_wstrb", 64'(ram_wstrb[i]), 0);
            chk("rst_ram_raddr", ram_raddr[i], 0);
        end
        reset = 0;
        issue(1, 64'h8000_0003, 0, 0, 64'hAB, 1);
        issue(0, 64'h8000_0003, 0, 0, 0, 1);
        issue(0, 64'h8000_0003, 0, 1, 0, 1);
        issue(1, 64'h8000_0006, 1, 0, 64'h8001, 1);
        issue(0, 64'h8000_0006, 1, 1, 0, 1);
        issue(0, 64'h8000_0008, 3, 0, 0, 1);
        issue(0, 64'h8000_0002, 2, 0, 0, 1);
        issue(1, 64'h8000_0005, 3, 0, 64'h1234, 1);
        // Backpressure: hold resp_ready low for several cycles once the slow instance responds
        rr_force = 0;
        issue(0, 64'h8000_0010, 2, 0, 0, 1);
        k = 0;
        while (!resp_valid[1] && k < 50) begin
            @(negedge clock);
            k++;
        end
        if (k >= 50) chk("bp_timeout", 1, 0);
        repeat (5) @(negedge clock);
        rr_force = 1;
        rr_rand = 1;
        repeat (150)
            issue($urandom_range(0, 1), 64'h8000_0000 + 64'($urandom_range(0, 63)), $urandom_range(0, 3),
                  $urandom_range(0, 1), {$urandom, $urandom}, 1);
        rr_rand = 0;
        k = 0;
        while ((sq[0].size() != 0 || sq[1].size() != 0) && k < 300) begin
            @(negedge clock);
            k++;
        end
        if (k >= 300) chk("drain_timeout", 1, 0);
        // Reset while both instances wait on read data
        issue(0, 64'h8000_0020, 3, 0, 0, 0);
        @(posedge clock);
        #2 reset = 1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_wait_wen", 64'(ram_wen[i]), 0);
            chk("rst_wait_valid", 64'(resp_valid[i]), 0);
        end
        @(negedge clock) reset = 0;
        // Reset in the cycle the store strobes the RAM
        issue(1, 64'h8000_0028, 3, 0, 64'hdead_beef_0bad_f00d, 0);
        for (int i = 0; i < 2; i++) chk("pre_rst_wen", 64'(ram_wen[i]), 1);
        #1 reset = 1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_store_wen", 64'(ram_wen[i]), 0);
            chk("rst_store_wstrb", 64'(ram_wstrb[i]), 0);
            chk("rst_store_valid", 64'(resp_valid[i]), 0);
        end
        @(negedge clock) reset = 0;
        last_raddr = 0;
        @(negedge clock);
        for (int i = 0; i < 2; i++) chk("post_rst_ready", 64'(req_ready[i]), 1);
        issue(1, 64'h8000_0028, 3, 0, 64'h0123_4567_89ab_cdef, 1);
        issue(0, 64'h8000_002c, 2, 0, 0, 1);
        issue(0, 64'h8000_0029, 0, 1, 0, 1);
        k = 0;
        while ((sq[0].size() != 0 || sq[1].size() != 0 || wq[0].size() != 0 || wq[1].size() != 0) && k < 300) begin
            @(negedge clock);
            k++;
        end
        if (k >= 300) chk("final_drain_timeout", 1, 0);
        repeat (3) @(negedge clock);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule

// File: doc/lsu_ram_master.md
Name: lsu_ram_master

Overview:
- Initiator side of the core's simulation RAM port. Takes one load/store request at a time from the LSU stage and drives the RAM's split read/write port.
- Stores: generates byte strobes and aligns write data to byte lanes.
- Loads: extracts the addressed bytes from returned data and sign- or zero-extends them.
- Returns each result on a valid/ready response channel. Sits between the pipeline's memory stage and the RAM controller.

Parameters:
- ADDR_W, 64, request and RAM address width.
- RD_LAT, 1, cycles from the first cycle ram_raddr is presented until ram_rdata is valid (>=1).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&ready
- req_wen  in  1  1=store, 0=load
- req_addr  in  ADDR_W  byte address
- req_size  in  2  0=byte, 1=half, 2=word, 3=double
- req_unsigned  in  1  loads only: zero-extend when 1
- req_wdata  in  64  store data, right-justified
- resp_valid  out  1  response valid
- resp_ready  in  1  response consumed when valid&ready
- resp_rdata  out  64  extended load data (0 for stores and errors)
- resp_err  out  1  misaligned access
- ram_raddr  out  ADDR_W  8-byte-aligned read address
- ram_rdata  in  64  read data
- ram_waddr  out  ADDR_W  8-byte-aligned write address
- ram_wdata  out  64  lane-aligned write data
- ram_wstrb  out  8  byte strobe
- ram_wen  out  1  write enable, one cycle per store

Behaviour:
- Reset (async, active-high): state=IDLE; req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, ram_wen=0, ram_wstrb=0, ram_raddr/ram_waddr/ram_wdata=0, wait counter=0.
- FSM states: IDLE, ACCESS, WAIT, RESP. All outputs are driven from registers.
- IDLE:
  - req_ready=1.
  - On accept, register wen, addr, size, unsigned, wdata.
  - misaligned = (addr & ((1<<size)-1)) != 0.
  - If misaligned -> RESP with err=1, rdata=0; no RAM access ever issued. Otherwise -> ACCESS.
- ACCESS (req_ready=0):
  - ram_raddr = ram_waddr = {addr[ADDR_W-1:3],3'b0}.
  - Store: ram_wen=1 for exactly this cycle.
    - ram_wstrb = ((1<<(1<<size))-1) << addr[2:0].
    - ram_wdata = (wdata masked to size) << (8*addr[2:0]); unused lanes are 0.
    - Next state RESP, err=0, rdata=0.
  - Load: ram_wen=0, ram_wstrb=0; load counter=RD_LAT-1; -> WAIT.
- WAIT (loads only):
  - ram_raddr held constant; counter decrements each cycle.
  - In the cycle the counter is 0, capture ram_rdata: shift right by 8*addr[2:0], keep low 8<<size bits, sign-extend from the top kept bit unless unsigned (size=3 passes through). -> RESP.
- RESP:
  - resp_valid=1; resp_rdata/resp_err held stable until resp_ready=1.
  - On handshake -> IDLE; req_ready returns to 1 the next cycle (no same-cycle re-accept).
- Latency (accept at cycle T):
  - store: wen in T+1, resp_valid in T+2.
  - load: resp_valid in T+2+RD_LAT.
  - error: resp_valid in T+1.
- Only one request is outstanding at a time. req_* inputs are ignored outside IDLE.
- reset asserted in any state: ram_wen drops immediately (async); any in-flight response is discarded.
- Address wrap: no carry into upper bits; the aligned address simply clears bits [2:0].

Decomposition:
- Shared package lsu_pkg:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D.
  - FSM state enum.
  - helper functions size_mask(size) and strb_gen(size, off).
- One sub-module, lsu_load_align: combinational extract and sign/zero extend from (rdata, off, size, unsigned) to 64-bit result. Also reused by the core's debug path.

Test Plan:
- Store byte 0xAB at 0x80000003 -> one cycle with ram_wen=1, ram_waddr=0x80000000, ram_wstrb=0x08, ram_wdata=0x00000000AB000000; resp_valid at T+2, resp_err=0.
- Signed load byte at 0x80000003, ram_rdata=0x00000000AB000000 -> resp_rdata=0xFFFFFFFFFFFFFFAB at T+3 (RD_LAT=1); same with req_unsigned=1 -> 0x00000000000000AB.
- Unsigned load half at 0x80000006, ram_rdata=0x8001000000000000 -> resp_rdata=0x0000000000008001; load double at 0x80000008 -> exact ram_rdata passthrough.
- Misaligned word load at 0x80000002 -> resp_err=1, resp_rdata=0 at T+1; ram_wen and ram_raddr never change.
- Backpressure: resp_ready=0 for 5 cycles -> resp_valid and resp_rdata held stable, req_ready=0 throughout; then resp_ready=1 -> req_ready=1 the next cycle. Also with RD_LAT=3: ram_raddr stable for 4 cycles, data captured on the last.
- Assert reset during WAIT and during an ACCESS store -> ram_wen=0 and resp_valid=0 immediately; after release, req_ready=1 and a fresh store completes normally.
